// File: rtl/instruction_fetcher.sv
// Instruction fetch unit: fetches one word per request from the memory controller and pushes {inst, pc} to the instruction queue.
// Define ICACHE_EN to add a direct-mapped, one-word-per-line instruction cache in front of memory.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  input  logic        iq_full,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_ack,
  input  logic [31:0] mc_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic        hit;
  logic [31:0] hit_word;
  logic        fill;

  assign pc_inc = pc + 32'd4;

  // A returning word is consumed whenever the fetcher is allowed to move (rdy or a redirect).
  assign fill = !rst && mc_req && mc_ack && (rdy || clear);

  logic unused_ok;
  assign unused_ok = &{1'b0, clear_pc[1:0]};

`ifdef ICACHE_EN
  localparam int IDX   = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX;

  logic [31:0]             cache_data [ICACHE_LINES];
  logic [TAG_W-1:0]        cache_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] cache_valid;
  logic [IDX-1:0]          rd_idx;
  logic [IDX-1:0]          wr_idx;

  assign rd_idx   = pc[IDX+1:2];
  assign wr_idx   = mc_addr[IDX+1:2];
  assign hit      = cache_valid[rd_idx] && (cache_tag[rd_idx] == pc[31:IDX+2]);
  assign hit_word = cache_data[rd_idx];

  // Flushed fetches still fill the cache: the word is valid for its address.
  always_ff @(posedge clk) begin
    if (fill) begin
      cache_data[wr_idx] <= mc_data;
      cache_tag[wr_idx]  <= mc_addr[31:IDX+2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= '0;
    end else if (fill) begin
      cache_valid[wr_idx] <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ICACHE_LINES[0];
  assign hit        = 1'b0;
  assign hit_word   = 32'h0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= IDLE;
      inst_valid <= 1'b0;
      mc_req     <= 1'b0;
      inst       <= 32'h0;
      inst_pc    <= 32'h0;
      mc_addr    <= 32'h0;
    end else if (clear) begin
      pc         <= {clear_pc[31:2], 2'b00};
      inst_valid <= 1'b0;
      if (state != IDLE) begin
        // An ack landing with the redirect retires the request; otherwise wait it out in FLUSH.
        if (mc_ack) begin
          mc_req <= 1'b0;
          state  <= IDLE;
        end else begin
          state  <= FLUSH;
        end
      end
    end else if (rdy) begin
      case (state)
        IDLE: begin
          inst_valid <= 1'b0;
          if (!iq_full) begin
            if (hit) begin
              inst_valid <= 1'b1;
              inst       <= hit_word;
              inst_pc    <= pc;
              pc         <= pc_inc;
            end else begin
              mc_req  <= 1'b1;
              mc_addr <= pc;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mc_ack) begin
            mc_req     <= 1'b0;
            inst       <= mc_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc_inc;
            state      <= IDLE;
          end
        end
        FLUSH: begin
          if (mc_ack) begin
            mc_req <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
